cache_ctrl_fsm: RTL and testbench
=================================

Name: cache_ctrl_fsm

Overview:
- Direct-mapped, write-back, write-allocate cache controller that sequences the cache data array (256 lines x 4 words x 32 bits).
- Holds the tag/valid/dirty store internally and accepts one processor request at a time.
- Drives the data-array strobes: update_write, update_read, refil_write (line to memory), refil_read (line from memory).
- Runs the line-granular memory handshake for writeback and refill.

Parameters:
TAG_W, 20, tag width; address split is tag[31:12], index[11:4], word[3:2], byte[1:0].
LINES, 256, number of cache lines; index width is 8.
CNT_W, 16, width of the saturating hit and miss counters.

Ports:
clk  in  1  clock
rst  in  1  reset
cpu_req_valid  in  1  processor request strobe
cpu_req_we  in  1  1 = write, 0 = read
cpu_req_addr  in  32  byte address
cpu_req_wdata  in  32  write data
cpu_ready  out  1  controller idle, request accepted this cycle
cpu_resp_valid  out  1  one-cycle pulse: request complete; read data valid on data-array output
dp_index  out  8  line index to data array
dp_offset  out  4  word select to data array, {2'b00, word}
dp_wdata  out  32  latched write data to data array
dp_update_write  out  1  write word on hit
dp_update_read  out  1  read on hit
dp_refil_write  out  1  copy line to data-array memory-out register
dp_refil_read  out  1  load line from memory data bus
mem_req_valid  out  1  memory request, held until mem_ack
mem_req_we  out  1  1 = writeback, 0 = refill
mem_req_addr  out  32  line-aligned address, [3:0]=0
mem_ack  in  1  one-cycle memory completion; refill data valid on data_in_mem in this cycle
stat_hits  out  CNT_W  saturating hit count
stat_misses  out  CNT_W  saturating miss count

Behaviour:
- Reset: rst is synchronous and active-low; clock is clk, rising edge. On reset:
  - FSM goes to IDLE; all valid and dirty bits clear; counters clear.
  - All strobes, mem_req_valid, mem_req_we and cpu_resp_valid are 0; cpu_ready is 0 during reset.
  - mem_req_addr, dp_index, dp_offset and dp_wdata are 0.
  - A reset mid-transaction abandons it; no response is issued.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE, RESPOND.
- IDLE:
  - cpu_ready = 1.
  - On cpu_req_valid, latch addr, we and wdata, then go to COMPARE.
  - cpu_req_* is ignored whenever cpu_ready = 0.
- COMPARE:
  - hit = valid[idx] && tag[idx] == req_tag.
  - Hit write: dp_update_write = 1 for one cycle, dirty[idx] <= 1, stat_hits++, go to RESPOND.
  - Hit read: dp_update_read = 1 for one cycle, stat_hits++, go to RESPOND.
  - Miss with valid and dirty line: dp_refil_write = 1 for one cycle, stat_misses++, go to WRITEBACK.
  - Miss with clean or invalid line: stat_misses++, go to ALLOCATE.
  - A re-entry to COMPARE after a refill does not increment any counter.
- WRITEBACK:
  - mem_req_valid = 1, mem_req_we = 1, mem_req_addr = {stored_tag, idx, 4'h0}.
  - On mem_ack, go to ALLOCATE.
- ALLOCATE:
  - mem_req_valid = 1, mem_req_we = 0, mem_req_addr = {req_tag, idx, 4'h0}.
  - In the mem_ack cycle: dp_refil_read = 1, tag[idx] <= req_tag, valid <= 1, dirty <= 0, go to COMPARE.
- RESPOND: cpu_resp_valid = 1 for one cycle, then go to IDLE. Read data is registered by the data array at the end of COMPARE and is valid in this cycle.
- Memory-side rules:
  - mem_req_valid and mem_req_addr stay stable until mem_ack.
  - The WRITEBACK-to-ALLOCATE transition may drop mem_req_valid for zero cycles; mem_req_we changes in that case.
  - mem_ack outside WRITEBACK/ALLOCATE is ignored.
- Strobes: at most one dp_* strobe is high in any cycle. dp_index and dp_offset come from the latched request address.
- Latency: a hit takes 3 cycles from acceptance to response. A clean miss takes 3 cycles + memory latency + 1 (COMPARE re-entry). A dirty miss adds the writeback memory latency.
- Counters saturate at all ones.

Test Plan:
- Reset, then read 0x0000_1230 -> miss; ALLOCATE with mem_req_addr 0x0000_1230; dp_refil_read on ack; then dp_update_read; cpu_resp_valid; stat_misses = 1, stat_hits = 0.
- Write 0xDEADBEEF to 0x0000_1234, then read 0x0000_1234 -> both hit with 3-cycle latency; dp_offset = 1; read data 0xDEADBEEF; stat_hits = 2.
- Read 0x0001_1230 (same index 0x23, new tag, line dirty) -> dp_refil_write; WRITEBACK mem_req_addr 0x0000_1230 with we = 1; then ALLOCATE 0x0001_1230 with we = 0; response.
- Memory ack delayed 10 cycles -> mem_req_valid and mem_req_addr are held stable; cpu_ready stays 0; a cpu_req_valid pulse during the wait is ignored.
- Assert rst low during WRITEBACK -> next cycle IDLE, all strobes 0, no cpu_resp_valid; a re-read of the prior hit address now misses (valid bits cleared).
- Force stat_hits to all ones via 65 535+ hits (or a reduced-CNT_W build) -> counter holds at all ones.

Source files
------------

// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: processor, data-array and memory signals of the cache controller
interface cache_ctrl_if #(parameter int CNT_W = 16);
  logic             cpu_req_valid;
  logic             cpu_req_we;
  logic [31:0]      cpu_req_addr;
  logic [31:0]      cpu_req_wdata;
  logic             cpu_ready;
  logic             cpu_resp_valid;
  logic [7:0]       dp_index;
  logic [3:0]       dp_offset;
  logic [31:0]      dp_wdata;
  logic             dp_update_write;
  logic             dp_update_read;
  logic             dp_refil_write;
  logic             dp_refil_read;
  logic             mem_req_valid;
  logic             mem_req_we;
  logic [31:0]      mem_req_addr;
  logic             mem_ack;
  logic [CNT_W-1:0] stat_hits;
  logic [CNT_W-1:0] stat_misses;
  modport master (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, mem_ack,
    output cpu_ready, cpu_resp_valid, dp_index, dp_offset, dp_wdata,
           dp_update_write, dp_update_read, dp_refil_write, dp_refil_read,
           mem_req_valid, mem_req_we, mem_req_addr, stat_hits, stat_misses
  );
  modport slave (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, mem_ack,
    input  cpu_ready, cpu_resp_valid, dp_index, dp_offset, dp_wdata,
           dp_update_write, dp_update_read, dp_refil_write, dp_refil_read,
           mem_req_valid, mem_req_we, mem_req_addr, stat_hits, stat_misses
  );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: direct-mapped write-back/write-allocate cache controller with tag store and hit/miss counters
module cache_ctrl_fsm #(
  parameter int TAG_W = 20,
  parameter int LINES = 256,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  cache_ctrl_if.master bus
);
  localparam int IDX_W = $clog2(LINES);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] COMPARE   = 3'd1;
  localparam logic [2:0] WRITEBACK = 3'd2;
  localparam logic [2:0] ALLOCATE  = 3'd3;
  localparam logic [2:0] RESPOND   = 3'd4;
  logic [2:0]       state_q, state_d;
  logic [31:2]      addr_q;
  logic             we_q;
  logic [31:0]      wdata_q;
  logic             refill_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [LINES-1:0] valid_q, dirty_q;
  logic [CNT_W-1:0] hits_q, miss_q;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] idx;
  logic             hit, dirty_line, s_idle, s_cmp, s_wb, s_al, s_rsp, accept, fill;
  assign req_tag    = addr_q[31:32-TAG_W];
  assign idx        = addr_q[IDX_W+3:4];
  assign hit        = valid_q[idx] && tag_q[idx] == req_tag;
  assign dirty_line = valid_q[idx] && dirty_q[idx];
  // Every output is gated by rst so the bus is quiet throughout a reset cycle
  assign s_idle = rst && state_q == IDLE;
  assign s_cmp  = rst && state_q == COMPARE;
  assign s_wb   = rst && state_q == WRITEBACK;
  assign s_al   = rst && state_q == ALLOCATE;
  assign s_rsp  = rst && state_q == RESPOND;
  assign accept = s_idle && bus.cpu_req_valid;
  assign fill   = s_al && bus.mem_ack;
  assign bus.cpu_ready       = s_idle;
  assign bus.cpu_resp_valid  = s_rsp;
  assign bus.dp_index        = rst ? idx : '0;
  assign bus.dp_offset       = rst ? {2'b00, addr_q[3:2]} : '0;
  assign bus.dp_wdata        = rst ? wdata_q : '0;
  assign bus.dp_update_write = s_cmp && hit && we_q;
  assign bus.dp_update_read  = s_cmp && hit && !we_q;
  assign bus.dp_refil_write  = s_cmp && !hit && dirty_line;
  assign bus.dp_refil_read   = fill;
  assign bus.mem_req_valid   = s_wb || s_al;
  assign bus.mem_req_we      = s_wb;
  assign bus.mem_req_addr    = s_wb ? {tag_q[idx], idx, 4'h0} : s_al ? {req_tag, idx, 4'h0} : '0;
  assign bus.stat_hits       = hits_q;
  assign bus.stat_misses     = miss_q;
  always_comb begin
    state_d = (state_q == IDLE)      ? (bus.cpu_req_valid ? COMPARE : IDLE) :
              (state_q == COMPARE)   ? (hit ? RESPOND : dirty_line ? WRITEBACK : ALLOCATE) :
              (state_q == WRITEBACK) ? (bus.mem_ack ? ALLOCATE : WRITEBACK) :
              (state_q == ALLOCATE)  ? (bus.mem_ack ? COMPARE : ALLOCATE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (fill) tag_q[idx] <= req_tag;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      refill_q <= 1'b0;
      valid_q  <= '0;
      dirty_q  <= '0;
      hits_q   <= '0;
      miss_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= bus.cpu_req_addr[31:2];
        we_q     <= bus.cpu_req_we;
        wdata_q  <= bus.cpu_req_wdata;
        refill_q <= 1'b0;
      end
      // refill_q marks the post-refill COMPARE so a miss is counted once
      if (s_cmp && !refill_q && hit) hits_q <= hits_q + {{(CNT_W-1){1'b0}}, ~&hits_q};
      if (s_cmp && !refill_q && !hit) miss_q <= miss_q + {{(CNT_W-1){1'b0}}, ~&miss_q};
      if (s_cmp && hit && we_q) dirty_q[idx] <= 1'b1;
      if (fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
        refill_q     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb_cache_ctrl_fsm: directed scenarios for the cache controller, counters built 4 bits wide to reach saturation
module tb_cache_ctrl_fsm;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  always #5 clk = ~clk;
  cache_ctrl_if #(.CNT_W(4)) bus ();
  cache_ctrl_fsm #(.CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [3:0] strobes();
    return {bus.dp_update_write, bus.dp_update_read, bus.dp_refil_write, bus.dp_refil_read};
  endfunction

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_we    = we;
    bus.cpu_req_addr  = addr;
    bus.cpu_req_wdata = wd;
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_we    = 1'b0;
    bus.cpu_req_addr  = '0;
    bus.cpu_req_wdata = '0;
    bus.mem_ack       = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.cpu_ready, bus.cpu_resp_valid, bus.mem_req_valid, bus.mem_req_we, strobes()} !== 8'h00) begin
      fails++; $display("FAIL reset_ctrl: got %b want 00000000", {bus.cpu_ready, bus.cpu_resp_valid, bus.mem_req_valid, bus.mem_req_we, strobes()});
    end
    tests++;
    if ({bus.mem_req_addr, bus.dp_index, bus.dp_offset, bus.dp_wdata, bus.stat_hits, bus.stat_misses} !== 84'h0) begin
      fails++; $display("FAIL reset_data: addr %h idx %h off %h wd %h hits %h miss %h, want all 0", bus.mem_req_addr, bus.dp_index, bus.dp_offset, bus.dp_wdata, bus.stat_hits, bus.stat_misses);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.cpu_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", bus.cpu_ready); end
  endtask

  task automatic test_read_miss();
    issue(1'b0, 32'h0000_1230, 32'h0);
    tests++;
    if (strobes() !== 4'b0000 || bus.dp_index !== 8'h23) begin fails++; $display("FAIL miss_compare: strobes %b idx %h want 0000 23", strobes(), bus.dp_index); end
    @(negedge clk);
    tests++;
    if ({bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr} !== {2'b10, 32'h0000_1230}) begin
      fails++; $display("FAIL miss_alloc: got v%b we%b %h want v1 we0 00001230", bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr);
    end
    bus.mem_ack = 1'b1;
    #1;
    tests++;
    if (strobes() !== 4'b0001) begin fails++; $display("FAIL miss_refil_read: got %b want 0001", strobes()); end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    tests++;
    if (strobes() !== 4'b0100) begin fails++; $display("FAIL miss_reenter: got %b want 0100", strobes()); end
    @(negedge clk);
    tests++;
    if (bus.cpu_resp_valid !== 1'b1 || strobes() !== 4'b0000) begin fails++; $display("FAIL miss_resp: resp %b strobes %b want 1 0000", bus.cpu_resp_valid, strobes()); end
    @(negedge clk);
    tests++;
    if ({bus.cpu_ready, bus.cpu_resp_valid, bus.stat_hits, bus.stat_misses} !== {2'b10, 4'd0, 4'd1}) begin
      fails++; $display("FAIL miss_done: ready %b resp %b hits %0d miss %0d want 1 0 0 1", bus.cpu_ready, bus.cpu_resp_valid, bus.stat_hits, bus.stat_misses);
    end
  endtask

  task automatic test_write_read_hit();
    issue(1'b1, 32'h0000_1234, 32'hDEAD_BEEF);
    tests++;
    if ({strobes(), bus.dp_offset, bus.dp_wdata} !== {4'b1000, 4'h1, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL hit_write: strobes %b off %h wd %h want 1000 1 deadbeef", strobes(), bus.dp_offset, bus.dp_wdata);
    end
    @(negedge clk);
    tests++;
    if (bus.cpu_resp_valid !== 1'b1) begin fails++; $display("FAIL hit_write_resp: got %b want 1", bus.cpu_resp_valid); end
    @(negedge clk);
    issue(1'b0, 32'h0000_1234, 32'h0);
    tests++;
    if ({strobes(), bus.dp_offset} !== {4'b0100, 4'h1}) begin fails++; $display("FAIL hit_read: strobes %b off %h want 0100 1", strobes(), bus.dp_offset); end
    @(negedge clk);
    tests++;
    if (bus.cpu_resp_valid !== 1'b1) begin fails++; $display("FAIL hit_read_resp: got %b want 1", bus.cpu_resp_valid); end
    @(negedge clk);
    tests++;
    if ({bus.stat_hits, bus.stat_misses} !== {4'd2, 4'd1}) begin fails++; $display("FAIL hit_counts: hits %0d miss %0d want 2 1", bus.stat_hits, bus.stat_misses); end
  endtask

  task automatic test_dirty_miss_slow_ack();
    issue(1'b0, 32'h0001_1230, 32'h0);
    tests++;
    if (strobes() !== 4'b0010) begin fails++; $display("FAIL dirty_refil_write: got %b want 0010", strobes()); end
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bus.cpu_req_valid = (i == 4);
      bus.cpu_req_we    = 1'b1;
      bus.cpu_req_addr  = 32'h0000_5670;
      tests++;
      if ({bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.cpu_ready} !== {2'b11, 32'h0000_1230, 1'b0}) begin
        fails++; $display("FAIL wb_hold[%0d]: v%b we%b %h rdy%b want v1 we1 00001230 rdy0", i, bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.cpu_ready);
      end
      @(negedge clk);
    end
    bus.cpu_req_valid = 1'b0;
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    tests++;
    if ({bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.stat_misses} !== {2'b10, 32'h0001_1230, 4'd2}) begin
      fails++; $display("FAIL dirty_alloc: v%b we%b %h miss %0d want v1 we0 00011230 2", bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.stat_misses);
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    tests++;
    if ({strobes(), bus.dp_index, bus.dp_offset} !== {4'b0100, 8'h23, 4'h0}) begin fails++; $display("FAIL dirty_reenter: strobes %b idx %h off %h want 0100 23 0", strobes(), bus.dp_index, bus.dp_offset); end
    @(negedge clk);
    tests++;
    if (bus.cpu_resp_valid !== 1'b1) begin fails++; $display("FAIL dirty_resp: got %b want 1", bus.cpu_resp_valid); end
    @(negedge clk);
    tests++;
    if ({bus.cpu_ready, bus.stat_hits, bus.stat_misses} !== {1'b1, 4'd2, 4'd2}) begin
      fails++; $display("FAIL dirty_done: ready %b hits %0d miss %0d want 1 2 2", bus.cpu_ready, bus.stat_hits, bus.stat_misses);
    end
  endtask

  task automatic test_reset_mid_writeback();
    issue(1'b1, 32'h0001_1234, 32'h1234_5678);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (bus.stat_hits !== 4'd3) begin fails++; $display("FAIL mid_prehit: got %0d want 3", bus.stat_hits); end
    issue(1'b0, 32'h0002_1230, 32'h0);
    @(negedge clk);
    tests++;
    if ({bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr} !== {2'b11, 32'h0001_1230}) begin
      fails++; $display("FAIL mid_wb: v%b we%b %h want v1 we1 00011230", bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({bus.cpu_ready, bus.cpu_resp_valid, bus.mem_req_valid, strobes()} !== {3'b100, 4'b0000}) begin
      fails++; $display("FAIL mid_after_rst: ready %b resp %b memv %b strobes %b want 1 0 0 0000", bus.cpu_ready, bus.cpu_resp_valid, bus.mem_req_valid, strobes());
    end
    @(negedge clk);
    issue(1'b0, 32'h0001_1234, 32'h0);
    tests++;
    if (strobes() !== 4'b0000) begin fails++; $display("FAIL mid_reread_miss: got %b want 0000", strobes()); end
    @(negedge clk);
    tests++;
    if ({bus.mem_req_valid, bus.mem_req_addr, bus.stat_hits, bus.stat_misses} !== {1'b1, 32'h0001_1230, 4'd0, 4'd1}) begin
      fails++; $display("FAIL mid_realloc: v%b %h hits %0d miss %0d want v1 00011230 0 1", bus.mem_req_valid, bus.mem_req_addr, bus.stat_hits, bus.stat_misses);
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 17; i++) begin
      issue(1'b0, 32'h0001_1234, 32'h0);
      repeat (2) @(negedge clk);
      if (i == 13) begin
        tests++;
        if (bus.stat_hits !== 4'd14) begin fails++; $display("FAIL sat_count: got %0d want 14", bus.stat_hits); end
      end
    end
    tests++;
    if ({bus.stat_hits, bus.stat_misses} !== {4'hF, 4'd1}) begin fails++; $display("FAIL sat_hold: hits %h miss %0d want f 1", bus.stat_hits, bus.stat_misses); end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    tests++;
    if ({bus.cpu_ready, bus.mem_req_valid, strobes()} !== {2'b10, 4'b0000}) begin
      fails++; $display("FAIL idle_ack_ignored: ready %b memv %b strobes %b want 1 0 0000", bus.cpu_ready, bus.mem_req_valid, strobes());
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_read_hit();
    test_dirty_miss_slow_ack();
    test_reset_mid_writeback();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
